// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud timing helpers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef logic [2:0] uart_state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    // Clock cycles per bit period (integer division, truncating).
    function automatic int calc_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

    // Cycles from start-bit edge detection to the middle of the start bit.
    function automatic int calc_half(input int clock_frequency, input int baud_rate);
        return calc_bit(clock_frequency, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input; resets to 1 (idle level of a UART line).
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: centre-samples each bit and hands bytes out over valid/ready.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | line high, waiting for a falling edge
//   START     | counting to mid start bit, re-check it is still low
//   DATA      | sampling the 8 data bits at their centres, LSB first
//   STOP      | counting to mid stop bit, deliver byte or flag framing error
//   WAIT_HIGH | after a framing error, hold until the line returns high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 idle,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int BIT  = calc_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF = calc_half(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int CW   = $clog2(BIT);

    localparam logic [CW-1:0] BIT_M1   = CW'(BIT - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [2:0]           bitcnt;
    logic [DATA_BITS-1:0] shift;
    logic                 cnt_zero;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (in),
        .q     (rx_s)
    );

    assign cnt_zero = (cnt == '0);
    assign idle     = (state == ST_IDLE);

    // Frame FSM, baud down-counter, shift register and output handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bitcnt    <= '0;
            shift     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= HALF_M1;
                    end
                end
                ST_START: begin
                    if (cnt_zero) begin
                        if (!rx_s) begin
                            state  <= ST_DATA;
                            cnt    <= BIT_M1;
                            bitcnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_zero) begin
                        shift  <= {rx_s, shift[DATA_BITS-1:1]};
                        bitcnt <= bitcnt + 3'd1;
                        cnt    <= BIT_M1;
                        if (bitcnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt_zero) begin
                        if (rx_s) begin
                            state    <= ST_IDLE;
                            data_out <= shift;
                            valid    <= 1'b1;
                            // Taking over an unconsumed byte is an overrun unless
                            // the consumer is accepting it on this very edge.
                            if (valid && !ready) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state     <= ST_WAIT_HIGH;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
